// File: rtl/sine_meas_pkg.sv
// Shared types and constants for the sine period meter.
package sine_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } meas_state_t;

  localparam int DEF_DW   = 10;
  localparam int DEF_MID  = 512;
  localparam int DEF_HYST = 16;

  function automatic int lo_th(input int mid, input int hyst);
    return mid - hyst;
  endfunction

  function automatic int hi_th(input int mid, input int hyst);
    return mid + hyst;
  endfunction

endpackage

// File: rtl/sine_period_meter_if.sv
// Sample stream in, per-period measurement results out.
import sine_meas_pkg::*;

interface sine_period_meter_if #(
  parameter int DW = DEF_DW,
  parameter int PW = 16
);
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic          result_valid;
  logic [PW-1:0] period;
  logic [DW-1:0] peak_max;
  logic [DW-1:0] peak_min;
  logic          locked;
  logic          timeout;

  modport master (
    output sample_valid, sample_in,
    input  result_valid, period, peak_max, peak_min, locked, timeout
  );

  modport slave (
    input  sample_valid, sample_in,
    output result_valid, period, peak_max, peak_min, locked, timeout
  );
endinterface

// File: rtl/sample_extrema_tracker.sv
// Running max/min of the samples seen since the last load.
import sine_meas_pkg::*;

module sample_extrema_tracker #(
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          update,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] max_val,
  output logic [DW-1:0] min_val
);

  always_ff @(posedge clock) begin
    if (reset) begin
      max_val <= '0;
      min_val <= '0;
    end else if (load) begin
      max_val <= sample;
      min_val <= sample;
    end else if (update) begin
      if (sample > max_val) max_val <= sample;
      if (sample < min_val) min_val <= sample;
    end
  end

endmodule

// File: rtl/sine_period_meter.sv
// Rising mid-crossing detector with hysteresis; publishes period and peaks per cycle.
//   state  | meaning
//   S_IDLE | waiting for a sample at or below LO_TH
//   S_ARM  | armed, waiting for the first rising crossing
//   S_HIGH | counting, signal above band
//   S_LOW  | counting, signal below band; next crossing publishes
import sine_meas_pkg::*;

module sine_period_meter #(
  parameter int DW         = DEF_DW,
  parameter int MID        = DEF_MID,
  parameter int HYST       = DEF_HYST,
  parameter int PW         = 16,
  parameter int MAX_PERIOD = 65535
) (
  input logic                 clock,
  input logic                 reset,
  sine_period_meter_if.slave  bus
);

  localparam logic [DW-1:0] LO_TH   = DW'(lo_th(MID, HYST));
  localparam logic [DW-1:0] HI_TH   = DW'(hi_th(MID, HYST));
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PERIOD);

  meas_state_t   state;
  logic [PW-1:0] cnt;
  logic          result_valid;
  logic [PW-1:0] period;
  logic [DW-1:0] peak_max;
  logic [DW-1:0] peak_min;
  logic          locked;
  logic          timeout;
  logic [DW-1:0] run_max;
  logic [DW-1:0] run_min;

  logic is_low, is_high, crossing, counting, track_update;

  assign is_low       = bus.sample_in <= LO_TH;
  assign is_high      = bus.sample_in >= HI_TH;
  assign counting     = (state == S_HIGH) || (state == S_LOW);
  assign crossing     = bus.sample_valid && is_high && ((state == S_ARM) || (state == S_LOW));
  assign track_update = bus.sample_valid && counting && !crossing;

  // Tracker outputs are registered, so a publish reads the period before the crossing sample.
  sample_extrema_tracker #(.DW(DW)) u_tracker (
    .clock   (clock),
    .reset   (reset),
    .load    (crossing),
    .update  (track_update),
    .sample  (bus.sample_in),
    .max_val (run_max),
    .min_val (run_min)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      period       <= '0;
      peak_max     <= '0;
      peak_min     <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      if (bus.sample_valid) begin
        unique case (state)
          S_IDLE: if (is_low) state <= S_ARM;
          S_ARM: begin
            if (is_high) begin
              cnt   <= PW'(1);
              state <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (cnt == MAX_CNT) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              cnt <= cnt + PW'(1);
              if (is_low) state <= S_LOW;
            end
          end
          S_LOW: begin
            if (is_high) begin
              result_valid <= 1'b1;
              period       <= cnt;
              peak_max     <= run_max;
              peak_min     <= run_min;
              locked       <= 1'b1;
              cnt          <= PW'(1);
              state        <= S_HIGH;
            end else if (cnt == MAX_CNT) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              cnt <= cnt + PW'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.result_valid = result_valid;
  assign bus.period       = period;
  assign bus.peak_max     = peak_max;
  assign bus.peak_min     = peak_min;
  assign bus.locked       = locked;
  assign bus.timeout      = timeout;

endmodule
